// File: rtl/left_down_fifo_writer_if.sv
// Write side of the Left/Down pixel FIFO pair: per-FIFO write strobe, pixel data and full flag.
interface left_down_fifo_writer_if;
    logic        full_left;
    logic        full_down;
    logic        wr_en_Left_FIFO;
    logic        wr_en_Down_FIFO;
    logic [23:0] RGB_data_left_in;
    logic [23:0] RGB_data_down_in;

    modport master (
        input  full_left,
        input  full_down,
        output wr_en_Left_FIFO,
        output wr_en_Down_FIFO,
        output RGB_data_left_in,
        output RGB_data_down_in
    );

    modport slave (
        output full_left,
        output full_down,
        input  wr_en_Left_FIFO,
        input  wr_en_Down_FIFO,
        input  RGB_data_left_in,
        input  RGB_data_down_in
    );
endinterface

// File: rtl/left_down_fifo_writer.sv
// Splits the first LEFT_COLS pixels of each active video line into the Left FIFO and the
// next DOWN_COLS pixels into the Down FIFO, within the line window FIRST_LINE..LAST_LINE.
module left_down_fifo_writer #(
    parameter int LEFT_COLS  = 45,
    parameter int DOWN_COLS  = 78,
    parameter int FIRST_LINE = 0,
    parameter int LAST_LINE  = 1055
) (
    input  logic                    clk_HDMI,
    input  logic                    reset,
    input  logic                    vs,
    input  logic                    hs,
    input  logic                    de,
    input  logic [23:0]             RGB_data_in,
    left_down_fifo_writer_if.master fifo,
    output logic [12:0]             line_count,
    output logic                    frame_done,
    output logic                    overflow
);

    localparam logic [12:0] LEFT_LAST = 13'(LEFT_COLS - 1);
    localparam logic [12:0] ROW_LAST  = 13'(LEFT_COLS + DOWN_COLS - 1);
    localparam logic [13:0] FIRST_P1  = 14'(FIRST_LINE + 1);
    localparam logic [12:0] LAST_L    = 13'(LAST_LINE);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        CAP_LEFT,
        CAP_DOWN,
        SKIP
    } state_t;

    state_t      state, state_nx;
    logic [12:0] col, col_nx;
    logic [12:0] line_nx;
    logic [12:0] pix_col;
    logic        vs_d;
    logic        vs_fall;
    logic        line_in_range;
    logic        capture;
    logic        end_line;
    logic        take_left;
    logic        take_down;
    logic        drop;
    logic        done_nx;

    // Decision stage: the write chosen on the sampling edge, presented to the FIFO one edge later.
    logic        wr_left_p;
    logic        wr_down_p;
    logic [23:0] data_left_p;
    logic [23:0] data_down_p;

    logic        hs_unused;
    assign hs_unused = hs;

    assign vs_fall = vs_d & ~vs;

    // Lower bound written as line+1 > FIRST so a zero FIRST_LINE is not a constant compare.
    assign line_in_range = (({1'b0, line_count} + 14'd1) >= FIRST_P1) &&
                           (line_count <= LAST_L);

    always_comb begin
        state_nx  = state;
        col_nx    = col;
        line_nx   = line_count;
        pix_col   = col;
        capture   = 1'b0;
        end_line  = 1'b0;
        take_left = 1'b0;
        take_down = 1'b0;
        drop      = 1'b0;
        done_nx   = 1'b0;

        if (vs) begin
            state_nx = IDLE;
            col_nx   = '0;
            line_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (vs_fall) state_nx = WAIT_LINE;
                end
                WAIT_LINE: begin
                    if (de) begin
                        if (line_in_range) begin
                            capture = 1'b1;
                            pix_col = '0;
                        end else begin
                            state_nx = SKIP;
                            col_nx   = 13'd1;
                        end
                    end
                end
                CAP_LEFT, CAP_DOWN: begin
                    if (de) capture = 1'b1;
                    else    end_line = 1'b1;
                end
                SKIP: begin
                    if (!de)              end_line = 1'b1;
                    else if (col != '1)   col_nx = col + 13'd1;
                end
                default: state_nx = IDLE;
            endcase

            if (capture) begin
                col_nx = pix_col + 13'd1;
                if (pix_col == ROW_LAST)       state_nx = SKIP;
                else if (pix_col >= LEFT_LAST) state_nx = CAP_DOWN;
                else                           state_nx = CAP_LEFT;

                // A full target drops the pixel but the column still advances.
                if (pix_col <= LEFT_LAST) begin
                    if (fifo.full_left) drop = 1'b1;
                    else                take_left = 1'b1;
                end else begin
                    if (fifo.full_down) drop = 1'b1;
                    else                take_down = 1'b1;
                end
            end

            if (end_line) begin
                state_nx = WAIT_LINE;
                col_nx   = '0;
                if (line_count != '1) line_nx = line_count + 13'd1;
                done_nx  = (line_count == LAST_L);
            end
        end
    end

    always_ff @(posedge clk_HDMI) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk_HDMI) begin
        if (reset) begin
            col                   <= '0;
            line_count            <= '0;
            vs_d                  <= 1'b0;
            frame_done            <= 1'b0;
            overflow              <= 1'b0;
            wr_left_p             <= 1'b0;
            wr_down_p             <= 1'b0;
            data_left_p           <= '0;
            data_down_p           <= '0;
            fifo.wr_en_Left_FIFO  <= 1'b0;
            fifo.wr_en_Down_FIFO  <= 1'b0;
            fifo.RGB_data_left_in <= '0;
            fifo.RGB_data_down_in <= '0;
        end else begin
            col        <= col_nx;
            line_count <= line_nx;
            vs_d       <= vs;
            frame_done <= done_nx;
            if (drop) overflow <= 1'b1;

            wr_left_p <= take_left;
            wr_down_p <= take_down;
            if (take_left) data_left_p <= RGB_data_in;
            if (take_down) data_down_p <= RGB_data_in;

            fifo.wr_en_Left_FIFO <= wr_left_p;
            fifo.wr_en_Down_FIFO <= wr_down_p;
            if (wr_left_p) fifo.RGB_data_left_in <= data_left_p;
            if (wr_down_p) fifo.RGB_data_down_in <= data_down_p;
        end
    end

endmodule

// File: tb/tb_left_down_fifo_writer.sv
// Directed bench for left_down_fifo_writer: a default-sized instance and a small windowed one,
// with per-FIFO expected-pixel queues filled by the stimulus and drained by a write monitor.
module tb_left_down_fifo_writer;

    logic        clk_HDMI = 1'b0;
    logic        rst1, rst2;
    logic        vs, hs, de;
    logic [23:0] rgb;
    logic [12:0] lc1, lc2;
    logic        fd1, fd2, ov1, ov2;

    left_down_fifo_writer_if if1 ();
    left_down_fifo_writer_if if2 ();

    left_down_fifo_writer dut1 (
        .clk_HDMI    (clk_HDMI),
        .reset       (rst1),
        .vs          (vs),
        .hs          (hs),
        .de          (de),
        .RGB_data_in (rgb),
        .fifo        (if1),
        .line_count  (lc1),
        .frame_done  (fd1),
        .overflow    (ov1)
    );

    left_down_fifo_writer #(
        .LEFT_COLS  (4),
        .DOWN_COLS  (3),
        .FIRST_LINE (2),
        .LAST_LINE  (3)
    ) dut2 (
        .clk_HDMI    (clk_HDMI),
        .reset       (rst2),
        .vs          (vs),
        .hs          (hs),
        .de          (de),
        .RGB_data_in (rgb),
        .fifo        (if2),
        .line_count  (lc2),
        .frame_done  (fd2),
        .overflow    (ov2)
    );

    always #5 clk_HDMI = ~clk_HDMI;

    int checks   = 0;
    int failures = 0;

    logic [23:0] lq1[$], dq1[$], lq2[$], dq2[$];
    int lw1 = 0, dw1 = 0, lw2 = 0, dw2 = 0, fdc2 = 0;

    int   sel, cur_l, cur_d, cur_first, cur_last;
    int   mline, mcol;
    bit   armed;
    logic exp_ovf1, exp_ovf2;
    int   exp_fd2;
    int   lb, db;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_HDMI);
        #1;
    endtask

    task automatic set_cfg(input int s);
        sel = s;
        if (s == 1) begin
            cur_l = 45; cur_d = 78; cur_first = 0; cur_last = 1055;
        end else begin
            cur_l = 4;  cur_d = 3;  cur_first = 2; cur_last = 3;
        end
    endtask

    task automatic push(input bit left, input logic [23:0] d);
        if (sel == 1) begin
            if (left) lq1.push_back(d); else dq1.push_back(d);
        end else begin
            if (left) lq2.push_back(d); else dq2.push_back(d);
        end
    endtask

    task automatic note_drop();
        if (sel == 1) exp_ovf1 = 1'b1; else exp_ovf2 = 1'b1;
    endtask

    task automatic pix(input logic [23:0] d, input logic fl, input logic fd);
        de = 1'b1; rgb = d;
        if1.full_left = fl; if1.full_down = fd;
        if2.full_left = fl; if2.full_down = fd;
        if (armed && mline >= cur_first && mline <= cur_last) begin
            if (mcol < cur_l) begin
                if (fl) note_drop(); else push(1'b1, d);
            end else if (mcol < cur_l + cur_d) begin
                if (fd) note_drop(); else push(1'b0, d);
            end
        end
        mcol++;
        tick();
    endtask

    task automatic line_end();
        de = 1'b0; hs = 1'b1;
        if1.full_left = 1'b0; if1.full_down = 1'b0;
        if2.full_left = 1'b0; if2.full_down = 1'b0;
        if (armed && sel == 2 && mline == cur_last) exp_fd2++;
        if (armed) mline++;
        mcol = 0;
        tick();
        hs = 1'b0;
    endtask

    task automatic flush();
        de = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_start();
        de = 1'b0; vs = 1'b1;
        tick(); tick();
        vs = 1'b0;
        tick(); tick();
        armed = 1'b1; mline = 0; mcol = 0;
    endtask

    // Every FIFO write must match the oldest expected pixel for that FIFO.
    always @(negedge clk_HDMI) begin
        logic [23:0] e;
        if (if1.wr_en_Left_FIFO) begin
            lw1++;
            chk("l1_expected_pending", 32'(lq1.size() != 0), 32'd1);
            if (lq1.size() != 0) begin
                e = lq1.pop_front();
                chk("l1_data", 32'(if1.RGB_data_left_in), 32'(e));
            end
        end
        if (if1.wr_en_Down_FIFO) begin
            dw1++;
            chk("d1_expected_pending", 32'(dq1.size() != 0), 32'd1);
            if (dq1.size() != 0) begin
                e = dq1.pop_front();
                chk("d1_data", 32'(if1.RGB_data_down_in), 32'(e));
            end
        end
        if (if2.wr_en_Left_FIFO) begin
            lw2++;
            chk("l2_expected_pending", 32'(lq2.size() != 0), 32'd1);
            if (lq2.size() != 0) begin
                e = lq2.pop_front();
                chk("l2_data", 32'(if2.RGB_data_left_in), 32'(e));
            end
        end
        if (if2.wr_en_Down_FIFO) begin
            dw2++;
            chk("d2_expected_pending", 32'(dq2.size() != 0), 32'd1);
            if (dq2.size() != 0) begin
                e = dq2.pop_front();
                chk("d2_data", 32'(if2.RGB_data_down_in), 32'(e));
            end
        end
        if (if1.wr_en_Left_FIFO || if1.wr_en_Down_FIFO)
            chk("wr_en_exclusive", 32'(if1.wr_en_Left_FIFO & if1.wr_en_Down_FIFO), 32'd0);
        if (fd2) fdc2++;
    end

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        vs = 1'b0; hs = 1'b0; de = 1'b0; rgb = '0;
        if1.full_left = 1'b0; if1.full_down = 1'b0;
        if2.full_left = 1'b0; if2.full_down = 1'b0;
        armed = 1'b0; mline = 0; mcol = 0;
        exp_ovf1 = 1'b0; exp_ovf2 = 1'b0; exp_fd2 = 0;
        set_cfg(1);

        // Reset state
        repeat (3) tick();
        chk("rst_wr_left",   32'(if1.wr_en_Left_FIFO), 32'd0);
        chk("rst_wr_down",   32'(if1.wr_en_Down_FIFO), 32'd0);
        chk("rst_data_left", 32'(if1.RGB_data_left_in), 32'd0);
        chk("rst_data_down", 32'(if1.RGB_data_down_in), 32'd0);
        chk("rst_line",      32'(lc1), 32'd0);
        chk("rst_done",      32'(fd1), 32'd0);
        chk("rst_ovf",       32'(ov1), 32'd0);
        chk("rst_state",     32'(dut1.state), 32'd0);
        rst1 = 1'b0;
        tick();

        // Full 200-pixel line, value = column index
        frame_start();
        chk("line_at_frame_start", 32'(lc1), 32'd0);
        lb = lw1; db = dw1;
        for (int c = 0; c < 200; c++) pix(24'(c), 1'b0, 1'b0);
        line_end();
        flush();
        chk("full_left_writes", 32'(lw1 - lb), 32'd45);
        chk("full_down_writes", 32'(dw1 - db), 32'd78);
        chk("full_line_count",  32'(lc1), 32'd1);
        chk("full_no_ovf",      32'(ov1), 32'(exp_ovf1));
        chk("full_queues_empty", 32'(lq1.size() + dq1.size()), 32'd0);

        // Latency of the first pixel, on a short 50-pixel line
        frame_start();
        lb = lw1; db = dw1;
        pix(24'hABCDEF, 1'b0, 1'b0);
        chk("lat_not_yet", 32'(if1.wr_en_Left_FIFO), 32'd0);
        pix(24'd1, 1'b0, 1'b0);
        chk("lat_wr_en", 32'(if1.wr_en_Left_FIFO), 32'd1);
        chk("lat_data",  32'(if1.RGB_data_left_in), 32'hABCDEF);
        for (int c = 2; c < 50; c++) pix(24'(c), 1'b0, 1'b0);
        line_end();
        flush();
        chk("short_left_writes", 32'(lw1 - lb), 32'd45);
        chk("short_down_writes", 32'(dw1 - db), 32'd5);
        chk("short_no_ovf",      32'(ov1), 32'(exp_ovf1));

        // Next line starts at col 0; full_down stalls cols 60..62
        lb = lw1; db = dw1;
        for (int c = 0; c < 200; c++)
            pix(24'h1000 + 24'(c), 1'b0, (c >= 60 && c <= 62) ? 1'b1 : 1'b0);
        line_end();
        flush();
        chk("stall_left_writes", 32'(lw1 - lb), 32'd45);
        chk("stall_down_writes", 32'(dw1 - db), 32'd75);
        chk("stall_ovf",         32'(ov1), 32'(exp_ovf1));
        chk("stall_line_count",  32'(lc1), 32'd2);

        // vs abort at col 20: pixel 19 is already in flight, then writes stop
        frame_start();
        lb = lw1;
        for (int c = 0; c < 20; c++) pix(24'h2000 + 24'(c), 1'b0, 1'b0);
        armed = 1'b0;
        vs = 1'b1;
        pix(24'h2014, 1'b0, 1'b0);
        chk("vs_abort_last_write", 32'(if1.wr_en_Left_FIFO), 32'd1);
        de = 1'b0;
        tick();
        chk("vs_abort_stopped", 32'(if1.wr_en_Left_FIFO), 32'd0);
        chk("vs_abort_state",   32'(dut1.state), 32'd0);
        chk("vs_abort_line",    32'(lc1), 32'd0);
        vs = 1'b0;
        flush();
        chk("vs_abort_left_writes", 32'(lw1 - lb), 32'd20);
        chk("vs_keeps_ovf",         32'(ov1), 32'(exp_ovf1));

        // Reset abort at col 20: the in-flight pixel 19 is discarded too
        frame_start();
        lb = lw1;
        for (int c = 0; c < 19; c++) pix(24'h3000 + 24'(c), 1'b0, 1'b0);
        armed = 1'b0;
        pix(24'h3013, 1'b0, 1'b0);
        rst1 = 1'b1;
        pix(24'h3014, 1'b0, 1'b0);
        chk("rst_abort_stopped", 32'(if1.wr_en_Left_FIFO), 32'd0);
        rst1 = 1'b0; de = 1'b0;
        exp_ovf1 = 1'b0;
        tick();
        chk("rst_abort_state", 32'(dut1.state), 32'd0);
        chk("rst_abort_line",  32'(lc1), 32'd0);
        chk("rst_abort_ovf",   32'(ov1), 32'(exp_ovf1));
        // Without a fresh vs falling edge nothing is captured
        for (int c = 0; c < 10; c++) pix(24'h4000 + 24'(c), 1'b0, 1'b0);
        line_end();
        flush();
        chk("rst_abort_left_writes", 32'(lw1 - lb), 32'd19);
        chk("idle_ignores_line",     32'(lc1), 32'd0);

        // Window FIRST_LINE=2..LAST_LINE=3 on the small instance
        rst1 = 1'b1; rst2 = 1'b0;
        tick();
        set_cfg(2);
        frame_start();
        for (int ln = 0; ln < 5; ln++) begin
            for (int c = 0; c < 10; c++) pix(24'(ln * 16 + c), 1'b0, 1'b0);
            line_end();
            flush();
            if (ln == 2) chk("win_no_done_yet", 32'(fdc2), 32'd0);
        end
        chk("win_left_writes",  32'(lw2), 32'd8);
        chk("win_down_writes",  32'(dw2), 32'd6);
        chk("win_done_pulses",  32'(fdc2), 32'(exp_fd2));
        chk("win_line_count",   32'(lc2), 32'd5);
        chk("win_ovf",          32'(ov2), 32'(exp_ovf2));
        chk("win_queues_empty", 32'(lq2.size() + dq2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
